serial_load_ctrl: RTL

SERIAL_LOAD_CTRL -- requirements
Module: serial_load_ctrl

---
 rtl/serial_load_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/serial_load_ctrl.sv
// -----------------------------------------------------------------------------
// serial_load_ctrl
// Loads a WIDTH-bit word, MSB first, into an internal chain of D flip-flops.
// A three-state FSM (IDLE -> SHIFT -> DONE -> IDLE) drives the serial bit and
// the shift enable, and pulses Done for one cycle when the chain holds the word.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset
//   start_i      load request, sampled only in IDLE
//   clear_i      synchronous clear of the chain, honoured only in IDLE (wins over start)
//   data_in_i    word to load, captured on the edge that accepts start_i
//   d_o          serial bit presented to the chain (0 outside SHIFT)
//   shift_en_o   high during the WIDTH shift cycles
//   busy_o       high in SHIFT and DONE
//   done_o       one-cycle pulse in DONE
//   q_o          parallel content of the chain
// -----------------------------------------------------------------------------
module serial_load_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_in_i,
    output logic             d_o,
    output logic             shift_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] q_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Next-state and datapath logic for the load sequencer.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_i) begin
                    q_d = {WIDTH{1'b0}};
                end else if (start_i) begin
                    hold_d  = data_in_i;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_SHIFT;
                end else begin
                    q_d = q_q;
                end
            end
            ST_SHIFT: begin
                // The chain takes the current MSB of hold; hold empties with 0 fill.
                q_d    = {q_q[WIDTH-2:0], hold_q[WIDTH-1]};
                hold_d = {hold_q[WIDTH-2:0], 1'b0};
                if (cnt_q == CNT_LAST) begin
                    // Counter wraps to 0 so it never exceeds WIDTH-1.
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            q_q     <= {WIDTH{1'b0}};
            hold_q  <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode directly from registered state, so reset clears them at once.
    assign d_o        = (state_q == ST_SHIFT) ? hold_q[WIDTH-1] : 1'b0;
    assign shift_en_o = (state_q == ST_SHIFT);
    assign busy_o     = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign done_o     = (state_q == ST_DONE);
    assign q_o        = q_q;

endmodule
